vectadd_from_sw_sig: RTL and testbench
======================================

Name: vectadd_from_sw_sig

Overview:
Avalon-MM slave that carries software commands to the vectadd hardware; the counterpart of the hardware-to-software status input port.
- Provides a software-written, registered output port `out_port`, with set and clear write aliases.
- Provides a timed one-shot strobe generator.
- Provides a go/ack/done handshake FSM that launches a vectadd run and reports its completion to software.

Parameters:
DW, 2, width of `out_port` and `strobe_out` (1..32)
RESET_VAL, 0, reset value of `out_port`
PULSE_CYCLES, 4, strobe duration in clk cycles (1..65535)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
address  input  3  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  DW  software-controlled level outputs
strobe_out  output  DW  timed pulse outputs
go  output  1  run request to hardware
ack_in  input  1  hardware accepted the request
done_in  input  1  hardware finished; single-cycle pulse or level

Behaviour:
- One clock; reset is synchronous and active-high. Reset may assert mid-operation; on the next posedge every register returns to its reset value.
- Reset values:
  - `out_port` = RESET_VAL.
  - `strobe_out` = 0, `go` = 0, `readdata` = 0.
  - FSM state = IDLE; `done_sticky` = 0; pulse counter = 0.
- Register map, write side (each bit is active on writes only):
  - addr 0 DATA: `out_port` <= writedata[DW-1:0].
  - addr 1 STATUS: writing 1 to bit1 clears `done_sticky`.
  - addr 2 PULSE: mask = writedata[DW-1:0].
  - addr 3 CTRL: writing 1 to bit0 starts the handshake.
  - addr 4 SET: `out_port` <= `out_port` | writedata[DW-1:0].
  - addr 5 CLR: `out_port` <= `out_port` & ~writedata[DW-1:0].
  - addr 6-7: writes ignored.
- Read mux: no read strobe. `readdata` is registered every cycle from the current `address`, so data appears 1 cycle after `address` is presented.
  - addr 1 reads {30'b0, `done_sticky`, busy}, where busy = (state != IDLE).
  - addr 0 read: see Optional Feature.
  - All other addresses read 0.
- Write effect is visible on outputs the cycle after the write.
- Pulse generator:
  - A PULSE write with nonzero mask sets `strobe_out` <= `strobe_out` | mask and loads the counter with PULSE_CYCLES.
  - The counter decrements each cycle. `strobe_out` clears when the counter goes 1->0, so a strobe is exactly PULSE_CYCLES cycles high.
  - A PULSE write while a pulse is active ORs in the new mask and reloads the counter (retrigger extends the pulse).
  - A mask of 0 does nothing.
- Handshake FSM:
  - IDLE: a CTRL bit0 write -> REQ.
  - REQ: `go` = 1. When `ack_in` = 1 -> BUSY; `go` deasserts the next cycle.
  - BUSY: when `done_in` = 1 -> DONE.
  - DONE: set `done_sticky` -> IDLE, taking one cycle.
  - `go` is high only in REQ.
  - A CTRL write while not in IDLE is ignored.
  - `ack_in` or `done_in` arriving in any state other than the one waiting for it is ignored.
  - If `ack_in` and `done_in` are both high in REQ: go to BUSY only; `done_in` must be seen in BUSY.
- Simultaneous events:
  - A STATUS clear write in the same cycle as the DONE set: the set wins.
  - SET and CLR are separate addresses, so they cannot collide.
  - DATA writes do not affect the FSM or the pulse generator.

Optional Feature:
VECTADD_FSW_READBACK_EN
- Defined: a read of addr 0 returns {zero-extend, `out_port`}.
- Undefined: addr 0 reads 0 (write-only port); the read mux path for `out_port` is removed.

Decomposition:
- Package `vectadd_sw_sig_pkg`:
  - address constants ADDR_DATA .. ADDR_CLR.
  - STATUS bit indices.
  - FSM state enum {IDLE, REQ, BUSY, DONE}.
- Sub-module `vectadd_pulse_gen`: parameterised by DW and PULSE_CYCLES; inputs load and mask, output `strobe_out`.
- The FSM and the register file stay in the top module.

Test Plan:
- Reset then DATA write 0x3 -> `out_port` = 2'b11 next cycle. Assert reset for 1 cycle -> `out_port` = RESET_VAL, `readdata` = 0.
- `out_port` = 2'b01; SET write 0x2 -> 2'b11; CLR write 0x1 -> 2'b10. With READBACK_EN, addr 0 reads 0x2 one cycle after `address` = 0; without it, reads 0.
- PULSE write 0x1, PULSE_CYCLES = 4 -> `strobe_out[0]` high exactly 4 cycles. Rewrite 0x2 at cycle 2 -> `strobe_out` = 2'b11 for 4 more cycles from the rewrite.
- CTRL write 1 -> `go` = 1 until `ack_in` (held 3 cycles later). STATUS reads busy = 1; `done_in` pulse -> STATUS = 0x2 two cycles later; STATUS write 0x2 -> reads 0x0.
- CTRL write while in BUSY -> no change. `ack_in` while IDLE -> `go` stays 0. `ack_in` and `done_in` together in REQ -> state BUSY, `done_sticky` = 0.
- Reset asserted in BUSY with `strobe_out` active -> next cycle `go` = 0, `strobe_out` = 0, STATUS = 0. A following `done_in` is ignored.

Source files
------------

// File: rtl/vectadd_sw_sig_pkg.sv
// rtl/vectadd_sw_sig_pkg.sv - register map, status bits and handshake states for vectadd_from_sw_sig
package vectadd_sw_sig_pkg;

  // Word addresses of the slave register map
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_PULSE  = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;

  // STATUS register bit positions (read: busy/done, write: done clear)
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  // CTRL register bit that launches a handshake
  localparam int unsigned CTRL_START_BIT = 0;

  // Width of the strobe duration counter
  localparam int unsigned PULSE_CW = 16;

  // Handshake state machine
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_e;

  // Build the STATUS read word from the busy flag and the sticky done flag
  function automatic logic [31:0] status_word(input logic busy, input logic done_sticky);
    logic [31:0] w;
    w = '0;
    w[STATUS_BUSY_BIT] = busy;
    w[STATUS_DONE_BIT] = done_sticky;
    return w;
  endfunction

endpackage

// File: rtl/vectadd_pulse_gen.sv
// rtl/vectadd_pulse_gen.sv - retriggerable one-shot strobe, PULSE_CYCLES clocks wide
module vectadd_pulse_gen
  import vectadd_sw_sig_pkg::*;
#(
  parameter int unsigned DW           = 2,
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [DW-1:0] mask_i,
  output logic [DW-1:0] strobe_o
);

  localparam logic [PULSE_CW-1:0] LOAD_VAL = PULSE_CW'(PULSE_CYCLES);

  logic [PULSE_CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]       strobe_q, strobe_d;

  // Load/retrigger ORs the mask in and restarts the count; strobes drop on the 1->0 step
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    if (load_i && (mask_i != '0)) begin
      strobe_d = strobe_q | mask_i;
      cnt_d    = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == PULSE_CW'(1)) begin
        strobe_d = '0;
      end
    end
  end

  // Counter and strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      strobe_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/vectadd_from_sw_sig.sv
// rtl/vectadd_from_sw_sig.sv - software-to-vectadd command slave; VECTADD_FSW_READBACK_EN enables addr 0 readback
module vectadd_from_sw_sig
  import vectadd_sw_sig_pkg::*;
#(
  parameter int unsigned    DW           = 2,
  parameter logic [DW-1:0]  RESET_VAL    = '0,
  parameter int unsigned    PULSE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    address,
  input  logic          chipselect,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic [DW-1:0] out_port,
  output logic [DW-1:0] strobe_out,
  output logic          go,
  input  logic          ack_in,
  input  logic          done_in
);

  logic          wr_en;
  logic [DW-1:0] wr_bits;
  logic          pulse_load;
  logic          start_req;
  logic          status_clr;
  logic          unused_ok;

  logic [DW-1:0] out_port_q, out_port_d;
  logic [31:0]   readdata_q, readdata_d;
  state_e        state_q;
  logic          go_q;
  logic          done_sticky_q;

  assign wr_en      = chipselect && !write_n;
  assign wr_bits    = writedata[DW-1:0];
  assign pulse_load = wr_en && (address == ADDR_PULSE);
  assign start_req  = wr_en && (address == ADDR_CTRL) && writedata[CTRL_START_BIT];
  assign status_clr = wr_en && (address == ADDR_STATUS) && writedata[STATUS_DONE_BIT];
  assign unused_ok  = ^writedata;

  // Level outputs: plain write, set alias and clear alias
  always_comb begin
    out_port_d = out_port_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: out_port_d = wr_bits;
        ADDR_SET:  out_port_d = out_port_q | wr_bits;
        ADDR_CLR:  out_port_d = out_port_q & ~wr_bits;
        default:   out_port_d = out_port_q;
      endcase
    end
  end

  // Output port register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port_q <= RESET_VAL;
    end else begin
      out_port_q <= out_port_d;
    end
  end

  // Read mux follows the current address every cycle; there is no read strobe
  always_comb begin
    readdata_d = '0;
    case (address)
`ifdef VECTADD_FSW_READBACK_EN
      ADDR_DATA:   readdata_d[DW-1:0] = out_port_q;
`endif
      ADDR_STATUS: readdata_d = status_word(state_q != IDLE, done_sticky_q);
      default:     readdata_d = '0;
    endcase
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  // Handshake FSM: go is held through REQ; DONE's sticky set overrides a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      go_q          <= 1'b0;
      done_sticky_q <= 1'b0;
    end else begin
      if (status_clr) begin
        done_sticky_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_req) begin
            state_q <= REQ;
            go_q    <= 1'b1;
          end
        end
        REQ: begin
          if (ack_in) begin
            state_q <= BUSY;
            go_q    <= 1'b0;
          end
        end
        BUSY: begin
          if (done_in) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_sticky_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          go_q    <= 1'b0;
        end
      endcase
    end
  end

  vectadd_pulse_gen #(
    .DW           (DW),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_gen (
    .clk      (clk),
    .reset    (reset),
    .load_i   (pulse_load),
    .mask_i   (wr_bits),
    .strobe_o (strobe_out)
  );

  assign out_port = out_port_q;
  assign readdata = readdata_q;
  assign go       = go_q;

endmodule

// File: tb/tb_vectadd_from_sw_sig.sv
// tb/tb_vectadd_from_sw_sig.sv - directed scoreboard bench for vectadd_from_sw_sig
module tb_vectadd_from_sw_sig;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  out_port;
  logic [1:0]  strobe_out;
  logic        go;
  logic        ack_in;
  logic        done_in;

  int n_cmp;
  int n_err;
  logic [31:0] sb_q[$];

  vectadd_from_sw_sig #(
    .DW           (2),
    .RESET_VAL    (2'b00),
    .PULSE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .strobe_out (strobe_out),
    .go         (go),
    .ack_in     (ack_in),
    .done_in    (done_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    ack_in     = 1'b0;
    done_in    = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    push_exp(32'h0); check("rst_out_port", 32'(out_port));
    push_exp(32'h0); check("rst_strobe", 32'(strobe_out));
    push_exp(32'h0); check("rst_go", 32'(go));
    push_exp(32'h0); check("rst_readdata", readdata);

    // DATA write then a one-cycle reset
    push_exp(32'h3);
    wr(3'd0, 32'h3);
    check("data_wr", 32'(out_port));
    push_exp(32'h0);
    push_exp(32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("data_rst_out", 32'(out_port));
    check("data_rst_rd", readdata);

    // SET / CLR aliases and addr 0 readback
    wr(3'd0, 32'h1);
    push_exp(32'h3);
    wr(3'd4, 32'h2);
    check("set_alias", 32'(out_port));
    push_exp(32'h2);
    wr(3'd5, 32'h1);
    check("clr_alias", 32'(out_port));
`ifdef VECTADD_FSW_READBACK_EN
    push_exp(32'h2);
`else
    push_exp(32'h0);
`endif
    address = 3'd0;
    tick();
    check("rd_addr0", readdata);

    // single strobe, exactly 4 cycles
    push_exp(32'h1);
    wr(3'd2, 32'h1);
    check("pulse_c1", 32'(strobe_out));
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h1);
      tick();
      check("pulse_hold", 32'(strobe_out));
    end
    push_exp(32'h0);
    tick();
    check("pulse_end", 32'(strobe_out));

    // retrigger at cycle 2 extends with the merged mask
    wr(3'd2, 32'h1);
    tick();
    push_exp(32'h3);
    wr(3'd2, 32'h2);
    check("retrig_c1", 32'(strobe_out));
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h3);
      tick();
      check("retrig_hold", 32'(strobe_out));
    end
    push_exp(32'h0);
    tick();
    check("retrig_end", 32'(strobe_out));

    // zero mask does nothing
    wr(3'd2, 32'h0);
    push_exp(32'h0);
    check("pulse_zero", 32'(strobe_out));

    // handshake: go held until ack arrives 3 cycles later
    push_exp(32'h1);
    wr(3'd3, 32'h1);
    check("go_set", 32'(go));
    address = 3'd1;
    tick();
    push_exp(32'h1);
    tick();
    check("go_held", 32'(go));
    push_exp(32'h1);
    check("status_busy_req", readdata);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    push_exp(32'h0);
    check("go_after_ack", 32'(go));

    // CTRL write in BUSY is ignored
    wr(3'd3, 32'h1);
    push_exp(32'h0);
    check("ctrl_in_busy_go", 32'(go));
    address = 3'd1;
    tick();
    push_exp(32'h1);
    check("status_busy", readdata);

    // done pulse -> STATUS shows done two cycles later, then clear it
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    tick();
    tick();
    push_exp(32'h2);
    check("status_done", readdata);
    wr(3'd1, 32'h2);
    tick();
    push_exp(32'h0);
    check("status_cleared", readdata);

    // ack while IDLE is ignored
    ack_in = 1'b1;
    tick();
    tick();
    ack_in = 1'b0;
    push_exp(32'h0);
    check("ack_idle_go", 32'(go));
    push_exp(32'h0);
    check("ack_idle_status", readdata);

    // ack and done together in REQ: BUSY only, no done
    wr(3'd3, 32'h1);
    ack_in  = 1'b1;
    done_in = 1'b1;
    tick();
    ack_in  = 1'b0;
    done_in = 1'b0;
    push_exp(32'h0);
    check("ackdone_go", 32'(go));
    address = 3'd1;
    tick();
    tick();
    push_exp(32'h1);
    check("ackdone_status", readdata);

    // STATUS clear in the same cycle as the DONE set: set wins
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    wr(3'd1, 32'h2);
    tick();
    push_exp(32'h2);
    check("set_beats_clr", readdata);
    wr(3'd1, 32'h2);
    tick();
    push_exp(32'h0);
    check("clr_after_race", readdata);

    // reset while BUSY with a strobe running
    wr(3'd3, 32'h1);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    push_exp(32'h3);
    wr(3'd2, 32'h3);
    check("midrst_strobe_on", 32'(strobe_out));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_exp(32'h0); check("midrst_go", 32'(go));
    push_exp(32'h0); check("midrst_strobe", 32'(strobe_out));
    push_exp(32'h0); check("midrst_rd", readdata);
    address = 3'd1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    tick();
    tick();
    push_exp(32'h0);
    check("midrst_done_ignored", readdata);

    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected values left unchecked", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
